thread_scheduler: RTL
=====================

// Module: thread_scheduler
// PURPOSE
//  Scheduler end of the context-cache interface. Reads the cache's waiting-queue summary
//  (waiting_thread_count / waiting_next_id / waiting_next_id2), issues requesting_thread /
//  requested_thread_id, and captures the returned context (requested_thread_return / out_thread_id)
//  into an output FIFO. The FIFO presents threads to the execute stage under valid/ready.
//  Execution credits limit threads in flight; credits return when the disposition stage retires a thread.
// PARAMETERS
//  ID_W          6    thread id width; equals $bits(thread_id_t)
//  CTX_W         512  context width; equals $bits(thread_program_stuct_t)
//  MAX_INFLIGHT  4    max threads issued and not yet retired (1..2**ID_W-1)
//  FIFO_DEPTH    2    output FIFO entries (power of 2, >=2)
// PORTS
//  clk                   in   1      clock, all state on posedge
//  rst_n                 in   1      asynchronous reset, active-low
//  sched_enable          in   1      0 = issue no new requests; in-flight traffic still drains
//  waiting_thread_count  in   ID_W   cache work-queue depth (registered in cache)
//  waiting_next_id       in   ID_W   queue head
//  waiting_next_id2      in   ID_W   queue second entry
//  requesting_thread     out  1      request strobe to cache, one cycle per thread
//  requested_thread_id   out  ID_W   id being requested
//  requested_thread_ret  in   CTX_W  context from cache, valid the cycle after a request
//  out_thread_id         in   ID_W   id returned with the context
//  exec_valid            out  1      FIFO head valid
//  exec_ready            in   1      execute stage accepts head
//  exec_thread           out  CTX_W  head context
//  exec_id               out  ID_W   head id
//  done_valid            in   1      disposition retired one thread (incoming_control.incoming)
//  inflight_count        out  ID_W   issued-not-retired count
//  err_credit            out  1      sticky: done_valid seen with inflight_count==0
// BEHAVIOUR
//  Reset (rst_n=0, async): requesting_thread=0, requested_thread_id=0, exec_valid=0,
//   exec_thread=0, exec_id=0, inflight_count=0, err_credit=0, FIFO empty, return-pending flag cleared.
//  requesting_thread and requested_thread_id are registered. The cache samples them at the end of
//   cycle k. Its context and waiting outputs update at that edge, so a request in cycle k returns
//   data in cycle k+1. The waiting info seen in k+1 already excludes the requested id.
//  Issue decision, made in cycle k for a request in k+1:
//   eff_cnt = waiting_thread_count - requesting_thread
//   id = requesting_thread ? waiting_next_id2 : waiting_next_id
//   issue = sched_enable && eff_cnt!=0 && inflight_count<MAX_INFLIGHT
//           && (fifo_count + requesting_thread + ret_pending) < FIFO_DEPTH
//   The room check does not count FIFO pops in cycle k (conservative).
//  The id2 path allows back-to-back requests with no bubble. It never requests the same id twice.
//  ret_pending <= requesting_thread. When ret_pending=1, push {out_thread_id, requested_thread_ret}.
//   A push never overflows, guaranteed by the room check. On overflow anyway (illegal), drop the push.
//  FIFO: first-word-fall-through. exec_valid = !empty. Pop on exec_valid && exec_ready.
//   Push and pop in the same cycle are both legal, including when full with push blocked upstream.
//  Credits: +1 per issued request (cycle requesting_thread=1), -1 per done_valid.
//   Both in one cycle: net 0. done_valid at 0: count stays 0, err_credit<=1 until reset.
//  sched_enable falling: any request already registered still completes and is captured.
//  Widths: all counters ID_W bits. No wrap, since MAX_INFLIGHT < 2**ID_W.
// TESTING
//  1 reset: count=3 ids 5,7 held, rst_n pulsed mid-request -> all outputs 0 at once,
//    first request 2 cycles after release
//  2 back-to-back: count=3 head=5 next2=7, exec_ready=1 -> requests id5 then id7 in consecutive cycles,
//    exec_id 5 then 7 one cycle after each
//  3 credit limit MAX_INFLIGHT=4, count=10, no done_valid -> exactly 4 requests, inflight_count=4;
//    one done_valid -> exactly one more request
//  4 FIFO full: exec_ready=0, count=5 -> 2 requests only, exec_valid held, id stable;
//    exec_ready=1 for 1 cycle -> one pop, one new request
//  5 done_valid with inflight 0 -> err_credit=1 sticky, inflight_count stays 0; simultaneous issue+done -> count unchanged
//  6 count=1 head=9 -> single request id9, no request of next2 garbage; sched_enable=0 -> requesting_thread stays 0

Source files
------------

// File: rtl/thread_scheduler.sv
// Scheduler side of the context-cache interface: requests waiting threads under
// execution credits and stages the returned contexts in a FWFT FIFO for execute.
module thread_scheduler #(
    parameter int ID_W         = 6,
    parameter int CTX_W        = 512,
    parameter int MAX_INFLIGHT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sched_enable,
    input  logic [ID_W-1:0]  waiting_thread_count,
    input  logic [ID_W-1:0]  waiting_next_id,
    input  logic [ID_W-1:0]  waiting_next_id2,
    output logic             requesting_thread,
    output logic [ID_W-1:0]  requested_thread_id,
    input  logic [CTX_W-1:0] requested_thread_ret,
    input  logic [ID_W-1:0]  out_thread_id,
    output logic             exec_valid,
    input  logic             exec_ready,
    output logic [CTX_W-1:0] exec_thread,
    output logic [ID_W-1:0]  exec_id,
    input  logic             done_valid,
    output logic [ID_W-1:0]  inflight_count,
    output logic             err_credit
);

    localparam int              AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ID_W-1:0] DEPTH_V = ID_W'(FIFO_DEPTH);
    localparam logic [ID_W-1:0] MAX_V   = ID_W'(MAX_INFLIGHT);

    logic [CTX_W-1:0] ctx_mem [FIFO_DEPTH];
    logic [ID_W-1:0]  id_mem  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [ID_W-1:0]  fifo_count;
    logic             ret_pending;

    logic             issue;
    logic [ID_W-1:0]  next_id;
    logic             cnt_ok;
    logic             credit_ok;
    logic             room_ok;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;

    assign exec_valid  = (fifo_count != '0);
    assign exec_thread = ctx_mem[rd_ptr];
    assign exec_id     = id_mem[rd_ptr];
    assign fifo_full   = (fifo_count == DEPTH_V);
    assign do_pop      = exec_valid && exec_ready;
    assign do_push     = ret_pending && (!fifo_full || do_pop);

    // A request already on the wire has consumed the queue head and a credit, but
    // the cache inputs and inflight_count only reflect it one edge later.
    always_comb begin
        next_id   = requesting_thread ? waiting_next_id2 : waiting_next_id;
        cnt_ok    = waiting_thread_count > ID_W'(requesting_thread);
        credit_ok = (inflight_count + ID_W'(requesting_thread)) < MAX_V;
        room_ok   = (fifo_count + ID_W'(requesting_thread) + ID_W'(ret_pending)) < DEPTH_V;
        issue     = sched_enable && cnt_ok && credit_ok && room_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            requesting_thread   <= 1'b0;
            requested_thread_id <= '0;
            ret_pending         <= 1'b0;
            inflight_count      <= '0;
            err_credit          <= 1'b0;
        end else begin
            requesting_thread <= issue;
            if (issue) begin
                requested_thread_id <= next_id;
            end
            ret_pending <= requesting_thread;
            case ({requesting_thread, done_valid})
                2'b10: inflight_count <= inflight_count + ID_W'(1);
                2'b01: begin
                    if (inflight_count == '0) begin
                        err_credit <= 1'b1;
                    end else begin
                        inflight_count <= inflight_count - ID_W'(1);
                    end
                end
                default: inflight_count <= inflight_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ctx_mem[i] <= '0;
                id_mem[i]  <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) begin
                ctx_mem[wr_ptr] <= requested_thread_ret;
                id_mem[wr_ptr]  <= out_thread_id;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= fifo_count + ID_W'(do_push) - ID_W'(do_pop);
        end
    end

endmodule
